// File: rtl/fma_drv_pkg.sv
// Shared types and constants for the FP16 FMA driver and its buffers.
package fma_drv_pkg;

    localparam int FP16_W   = 16;
    localparam int CNT_W    = 8;
    localparam int TRIPLE_W = 3 * FP16_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } drv_state_t;

    // One operand set for a*b+c, packed so it can live in a single FIFO word.
    typedef struct packed {
        logic [FP16_W-1:0] a;
        logic [FP16_W-1:0] b;
        logic [FP16_W-1:0] c;
    } fp16_triple_t;

endpackage

// File: rtl/fma_drv_fifo.sv
// Synchronous FIFO with show-ahead read. The caller guarantees that push
// only happens when not full (or together with a pop) and that pop only
// happens when not empty; push and pop in the same cycle keep occupancy.
module fma_drv_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    // Pointer and occupancy tracking; reset empties the FIFO without touching storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/fp16_fma_driver.sv
// Driver that buffers host operand triples, streams them into a fixed-latency
// FP16 FMA pipe and buffers the results for the host.
// Optional feature: define FMA_DRV_TIMEOUT_EN to add a DRAIN watchdog that
// gives up TIMEOUT cycles after the last returned result and flags err.
module fp16_fma_driver
    import fma_drv_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int LATENCY = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [FP16_W-1:0] wr_a,
    input  logic [FP16_W-1:0] wr_b,
    input  logic [FP16_W-1:0] wr_c,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              fma_in_valid,
    output logic [FP16_W-1:0] fma_a,
    output logic [FP16_W-1:0] fma_b,
    output logic [FP16_W-1:0] fma_c,
    input  logic              fma_out_valid,
    input  logic [FP16_W-1:0] fma_out,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [FP16_W-1:0] rd_data,
    output logic [CNT_W-1:0]  issued_cnt,
    output logic [CNT_W-1:0]  retired_cnt
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int DW = $clog2(LATENCY + 2);

    if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 || LATENCY < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("fp16_fma_driver: illegal DEPTH/LATENCY/TIMEOUT");
    end

    drv_state_t       r_state;
    logic [CNT_W-1:0] r_issued;
    logic [CNT_W-1:0] r_retired;
    logic             r_err;
    logic [DW-1:0]    r_disc;

    fp16_triple_t      w_op_wdata;
    fp16_triple_t      w_op_rdata;
    logic              w_op_full, w_op_empty, w_op_push, w_op_pop, w_last_pop;
    logic [CW-1:0]     w_op_count;
    logic [FP16_W-1:0] w_res_rdata;
    logic              w_res_full, w_res_empty, w_res_push, w_res_pop;
    logic [CW-1:0]     w_res_count;
    logic [CNT_W-1:0]  w_outstanding;
    logic [CNT_W:0]    w_inflight;
    logic              w_res_in, w_retire, w_stray, w_wd_expire;

    // Host side: pushes only accepted between runs.
    assign wr_ready   = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && !w_op_full;
    assign w_op_push  = wr_valid && wr_ready;
    assign w_op_wdata = {wr_a, wr_b, wr_c};

    // Issue throttle: every in-flight op must have a guaranteed result slot,
    // because the FMA return path cannot be back-pressured.
    assign w_outstanding = r_issued - r_retired;
    assign w_inflight    = {1'b0, w_outstanding} + (CNT_W+1)'(w_res_count);
    assign w_op_pop      = (r_state == ST_ISSUE) && !w_op_empty && (w_inflight < (CNT_W+1)'(DEPTH));
    assign w_last_pop    = w_op_pop && (w_op_count == CW'(1));

    // Results still in the pipe from before a reset are dropped for LATENCY cycles.
    assign w_res_in   = fma_out_valid && (r_disc == '0);
    assign w_retire   = w_res_in && (w_outstanding != '0);
    assign w_stray    = w_res_in && (w_outstanding == '0);
    assign w_res_pop  = !w_res_empty && rd_ready;
    assign w_res_push = w_res_in && (!w_res_full || w_res_pop);

    assign fma_in_valid = w_op_pop;
    assign fma_a        = w_op_pop ? w_op_rdata.a : '0;
    assign fma_b        = w_op_pop ? w_op_rdata.b : '0;
    assign fma_c        = w_op_pop ? w_op_rdata.c : '0;
    assign rd_valid     = !w_res_empty;
    assign rd_data      = w_res_empty ? '0 : w_res_rdata;
    assign busy         = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
    assign done         = (r_state == ST_DONE);
    assign err          = r_err;
    assign issued_cnt   = r_issued;
    assign retired_cnt  = r_retired;

    fma_drv_fifo #(.WIDTH(TRIPLE_W), .DEPTH(DEPTH)) u_op_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_op_push),
        .i_data  (w_op_wdata),
        .i_pop   (w_op_pop),
        .o_data  (w_op_rdata),
        .o_full  (w_op_full),
        .o_empty (w_op_empty),
        .o_count (w_op_count)
    );

    fma_drv_fifo #(.WIDTH(FP16_W), .DEPTH(DEPTH)) u_res_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_res_push),
        .i_data  (fma_out),
        .i_pop   (w_res_pop),
        .o_data  (w_res_rdata),
        .o_full  (w_res_full),
        .o_empty (w_res_empty),
        .o_count (w_res_count)
    );

    // Post-reset discard window covering ops issued just before reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                r_disc <= DW'(LATENCY);
        else if (r_disc != '0)  r_disc <= r_disc - 1'b1;
    end

`ifdef FMA_DRV_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] r_wd_cnt;

    // A result cycle loads 1 so that done lands exactly TIMEOUT cycles after it.
    assign w_wd_expire = (r_state == ST_DRAIN) && !fma_out_valid && (r_wd_cnt == WDW'(TIMEOUT - 1));

    // Watchdog: counts DRAIN cycles since the last returned result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         r_wd_cnt <= '0;
        else if (r_state != ST_DRAIN)    r_wd_cnt <= '0;
        else if (fma_out_valid)          r_wd_cnt <= WDW'(1);
        else if (!w_wd_expire)           r_wd_cnt <= r_wd_cnt + 1'b1;
    end
`else
    assign w_wd_expire = 1'b0;
`endif

    // Run control FSM with issue/retire counters and the sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_issued  <= '0;
            r_retired <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_op_pop) r_issued  <= r_issued + 1'b1;
            if (w_retire) r_retired <= r_retired + 1'b1;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    // A new run clears the previous run's error status.
                    if (start) begin
                        r_err <= 1'b0;
                        if (!w_op_empty) begin
                            r_state   <= ST_ISSUE;
                            r_issued  <= '0;
                            r_retired <= '0;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (w_last_pop) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_retire && (w_outstanding == CNT_W'(1))) begin
                        r_state <= ST_DONE;
                    end else if (w_wd_expire) begin
                        r_state <= ST_DONE;
                        r_err   <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_stray) r_err <= 1'b1;
        end
    end

endmodule
